tb_run_sequencer: RTL

Sequences one measurement run of the arithmetic testbench from a single host command, replacing manual host writes of the reset/enable/freeze control bits. It holds the testbench in reset for a fixed period, enables it for a programmed number of cycles, freezes it, waits for the frozen counters to settle across clock domains, then snapshots the data and event counters for host readout. It sits between the Avalon register block (start/abort/run_cycles in, status/snapshots out) and the testbench control inputs.

---
 rtl/tb_seq_pkg.sv | 21 ++
 rtl/tb_run_sequencer_if.sv | 33 +++
 rtl/seq_down_counter.sv | 28 ++
 rtl/tb_run_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/tb_seq_pkg.sv
// Shared state encodings and default timing constants for the run sequencer.
// Pure declarations: no latency, no flow control.
package tb_seq_pkg;

  localparam int DEF_WIDTH         = 32;
  localparam int DEF_RESET_CYCLES  = 4;
  localparam int DEF_SETTLE_CYCLES = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_RUN    = 3'd2,
    ST_FREEZE = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  function automatic logic state_busy(input seq_state_e s);
    return (s == ST_RESET) || (s == ST_RUN) || (s == ST_FREEZE);
  endfunction

endpackage

// File: rtl/tb_run_sequencer_if.sv
// Host/testbench-side bundle of the run sequencer: command, counter inputs, control and status.
// Level signals only; start/abort are single-cycle pulses, no backpressure.
interface tb_run_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] run_cycles;
  logic [WIDTH-1:0] i_data_ctr;
  logic [WIDTH-1:0] i_event_ctr;
  logic             o_tb_reset;
  logic             o_tb_enable;
  logic             o_tb_freeze;
  logic             o_busy;
  logic             o_done;
  logic             o_aborted;
  logic [WIDTH-1:0] o_data_snap;
  logic [WIDTH-1:0] o_event_snap;
  logic [2:0]       o_state;

  modport master (
    output start, abort, run_cycles, i_data_ctr, i_event_ctr,
    input  o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done, o_aborted,
           o_data_snap, o_event_snap, o_state
  );

  modport slave (
    input  start, abort, run_cycles, i_data_ctr, i_event_ctr,
    output o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done, o_aborted,
           o_data_snap, o_event_snap, o_state
  );

endinterface

// File: rtl/seq_down_counter.sv
// Loadable down counter with terminal-count flag; holds at zero instead of wrapping.
// One-cycle load/decrement latency, no backpressure.
module seq_down_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/tb_run_sequencer.sv
// Runs one reset/enable/freeze/snapshot sequence of the arithmetic testbench per start pulse.
// Registered outputs; start-to-done is RESET_CYCLES + N + SETTLE_CYCLES edges after start is sampled.
module tb_run_sequencer
  import tb_seq_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input logic                clk,
  input logic                reset,
  tb_run_sequencer_if.slave  bus
);

  localparam logic [WIDTH-1:0] RST_LOAD    = WIDTH'(RESET_CYCLES - 1);
  localparam logic [WIDTH-1:0] SETTLE_LOAD = WIDTH'(SETTLE_CYCLES - 1);

  seq_state_e       state, state_nxt;
  logic [WIDTH-1:0] run_len;
  logic             cnt_load, cnt_dec, cnt_tc;
  logic [WIDTH-1:0] cnt_val;
  logic             latch_run, abort_hit, capture;

  logic             tb_reset_q, tb_enable_q, tb_freeze_q;
  logic             busy_q, done_q, aborted_q;
  logic [WIDTH-1:0] data_snap_q, event_snap_q;

  seq_down_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    latch_run = 1'b0;
    abort_hit = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        // start outranks a coincident abort here; abort has nothing to stop
        if (bus.start) begin
          state_nxt = ST_RESET;
          cnt_load  = 1'b1;
          cnt_val   = RST_LOAD;
          latch_run = 1'b1;
        end
      end
      ST_RESET: begin
        if (bus.abort) begin
          state_nxt = ST_FREEZE;
          cnt_load  = 1'b1;
          cnt_val   = SETTLE_LOAD;
          abort_hit = 1'b1;
        end else if (cnt_tc) begin
          state_nxt = ST_RUN;
          cnt_load  = 1'b1;
          cnt_val   = run_len - WIDTH'(1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RUN: begin
        // abort is checked first so it wins even on the final counted cycle
        if (bus.abort) begin
          state_nxt = ST_FREEZE;
          cnt_load  = 1'b1;
          cnt_val   = SETTLE_LOAD;
          abort_hit = 1'b1;
        end else if ((run_len != '0) && cnt_tc) begin
          state_nxt = ST_FREEZE;
          cnt_load  = 1'b1;
          cnt_val   = SETTLE_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_FREEZE: begin
        if (cnt_tc) begin
          state_nxt = ST_DONE;
          capture   = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_len <= '0;
    end else if (latch_run) begin
      run_len <= bus.run_cycles;
    end
  end

  // Control/status flops are driven from the next state so they align with o_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tb_reset_q   <= 1'b1;
      tb_enable_q  <= 1'b0;
      tb_freeze_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      data_snap_q  <= '0;
      event_snap_q <= '0;
    end else begin
      tb_reset_q  <= (state_nxt == ST_IDLE) || (state_nxt == ST_RESET);
      tb_enable_q <= (state_nxt == ST_RUN) || (state_nxt == ST_FREEZE) ||
                     (state_nxt == ST_DONE);
      tb_freeze_q <= (state_nxt == ST_FREEZE) || (state_nxt == ST_DONE);
      busy_q      <= state_busy(state_nxt);
      done_q      <= (state_nxt == ST_DONE);
      if (latch_run) begin
        aborted_q <= 1'b0;
      end else if (abort_hit) begin
        aborted_q <= 1'b1;
      end
      if (capture) begin
        data_snap_q  <= bus.i_data_ctr;
        event_snap_q <= bus.i_event_ctr;
      end
    end
  end

  assign bus.o_tb_reset   = tb_reset_q;
  assign bus.o_tb_enable  = tb_enable_q;
  assign bus.o_tb_freeze  = tb_freeze_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_aborted    = aborted_q;
  assign bus.o_data_snap  = data_snap_q;
  assign bus.o_event_snap = event_snap_q;
  assign bus.o_state      = state;

endmodule
